hamming_fsk_tx_ctrl: RTL and testbench



---
 rtl/hamming_fsk_tx_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hamming_fsk_tx_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hamming_fsk_tx_ctrl.sv
// hamming_fsk_tx_ctrl
// Transmit-side frame controller for the FSK link. Accepts one byte per
// valid/ready handshake, Hamming(12,8)-encodes it and serializes the frame
// start(0), 12 code bits MSB-first, stop(1), each bit lasting BIT_PERIOD clocks.
//
// Codeword layout: bit index i holds Hamming position i+1, so parity bits sit
// at indices 0,1,3,7 (positions 1,2,4,8) and data bits d0..d7 at indices
// 2,4,5,6,8,9,10,11.
//
// Optional build macro HAM_ERR_INJ_EN: when defined, err_inj/err_pos can
// invert one codeword bit at acceptance. When undefined those inputs are ignored.
module hamming_fsk_tx_ctrl #(
  parameter int BIT_PERIOD = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       err_inj,
  input  logic [3:0] err_pos,
  output logic       fsk_bit,
  output logic       fsk_en,
  output logic       bit_strobe,
  output logic       busy,
  output logic       frame_done
);

  localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);
  localparam logic [TW-1:0] T_PENULT = TW'(BIT_PERIOD - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_idx;
  logic [11:0]   r_cw;
  logic          r_tx_ready;
  logic          r_fsk_bit;
  logic          r_fsk_en;
  logic          r_bit_strobe;
  logic          r_busy;
  logic          r_frame_done;

  logic [11:0]   w_enc;
  logic [11:0]   w_cw_capture;
  logic          w_bit_last;

  // HammingEncoder: 8-bit datain -> 12-bit dataout, even parity per position group
  function automatic logic [11:0] hamming_encode(input logic [7:0] d);
    logic [11:0] c;
    c[2]  = d[0];
    c[4]  = d[1];
    c[5]  = d[2];
    c[6]  = d[3];
    c[8]  = d[4];
    c[9]  = d[5];
    c[10] = d[6];
    c[11] = d[7];
    c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
    return c;
  endfunction

  assign w_enc      = hamming_encode(tx_data);
  assign w_bit_last = (r_timer == T_LAST);

`ifdef HAM_ERR_INJ_EN
  // Optional single-bit corruption; positions 12..15 leave the codeword intact
  assign w_cw_capture = (err_inj && (err_pos <= 4'd11)) ? (w_enc ^ (12'd1 << err_pos)) : w_enc;
`else
  logic w_unused_err;
  assign w_unused_err = ^{err_inj, err_pos};
  assign w_cw_capture = w_enc;
`endif

  // Frame FSM: bit timer, bit index, codeword capture and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_idx        <= '0;
      r_cw         <= '0;
      r_tx_ready   <= 1'b1;
      r_fsk_bit    <= 1'b1;
      r_fsk_en     <= 1'b0;
      r_bit_strobe <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_bit_strobe <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_valid && r_tx_ready) begin
            r_cw         <= w_cw_capture;
            r_state      <= S_START;
            r_timer      <= '0;
            r_tx_ready   <= 1'b0;
            r_busy       <= 1'b1;
            r_fsk_en     <= 1'b1;
            r_fsk_bit    <= 1'b0;
            r_bit_strobe <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_last) begin
            r_state      <= S_DATA;
            r_timer      <= '0;
            r_idx        <= 4'd11;
            r_fsk_bit    <= r_cw[11];
            r_bit_strobe <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_last) begin
            r_timer      <= '0;
            r_bit_strobe <= 1'b1;
            if (r_idx == 4'd0) begin
              r_state   <= S_STOP;
              r_fsk_bit <= 1'b1;
            end else begin
              r_idx     <= r_idx - 4'd1;
              r_fsk_bit <= r_cw[r_idx - 4'd1];
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_STOP: begin
          // frame_done is registered, so raise it one cycle ahead of the last stop cycle
          if (r_timer == T_PENULT) begin
            r_frame_done <= 1'b1;
          end
          if (w_bit_last) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_fsk_en   <= 1'b0;
            r_fsk_bit  <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready   = r_tx_ready;
  assign fsk_bit    = r_fsk_bit;
  assign fsk_en     = r_fsk_en;
  assign bit_strobe = r_bit_strobe;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hamming_fsk_tx_ctrl.sv
// Testbench for hamming_fsk_tx_ctrl with BIT_PERIOD=4.
// Codewords are hand-computed (index i = Hamming position i+1).
module tb_hamming_fsk_tx_ctrl;

  localparam int BP    = 4;
  localparam int FRAME = 14 * BP;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       err_inj;
  logic [3:0] err_pos;
  logic       fsk_bit;
  logic       fsk_en;
  logic       bit_strobe;
  logic       busy;
  logic       frame_done;

  int n_checks;
  int n_fail;

  hamming_fsk_tx_ctrl #(.BIT_PERIOD(BP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .err_inj    (err_inj),
    .err_pos    (err_pos),
    .fsk_bit    (fsk_bit),
    .fsk_en     (fsk_en),
    .bit_strobe (bit_strobe),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        inj;
    logic [3:0]  pos;
    logic [11:0] exp_cw;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receive-side reference decoder: syndrome correction then data extraction
  function automatic logic [7:0] ham_decode(input logic [11:0] c);
    logic [3:0]  s;
    logic [11:0] f;
    s = 4'd0;
    for (int i = 0; i < 12; i++) if (c[i]) s = s ^ 4'(i + 1);
    f = c;
    if (s != 4'd0 && s <= 4'd12) f[s - 4'd1] = ~f[s - 4'd1];
    return {f[11], f[10], f[9], f[8], f[6], f[5], f[4], f[2]};
  endfunction

  // Present a byte and wait (bounded) for the accepting edge
  task automatic do_accept(input logic [7:0] d, input logic inj, input logic [3:0] pos);
    int waited;
    @(negedge clk);
    tx_data  = d;
    err_inj  = inj;
    err_pos  = pos;
    tx_valid = 1'b1;
    waited   = 0;
    while (!tx_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_timeout", 32'(waited >= 200), 32'd0);
    @(posedge clk);
  endtask

  // Observe cycles 1..FRAME+1 after an accept edge; returns first cycle with ready&&valid
  task automatic watch_frame(input string name, input logic [11:0] exp_cw, input logic drop_valid,
                             output int acc_cycle, output logic [11:0] got_cw);
    int bad_line, bad_strobe, bad_ctrl, done_cycle, n_strobe;
    logic exp_bit;
    bad_line = 0; bad_strobe = 0; bad_ctrl = 0; done_cycle = 0; n_strobe = 0;
    acc_cycle = 0;
    got_cw = '0;
    #1;
    if (drop_valid) tx_valid = 1'b0;
    tx_data = 8'($urandom);
    err_inj = 1'($urandom);
    err_pos = 4'($urandom);
    for (int k = 1; k <= FRAME + 1; k++) begin
      @(negedge clk);
      if (k <= BP) exp_bit = 1'b0;
      else if (k <= 13 * BP) exp_bit = exp_cw[11 - (k - BP - 1) / BP];
      else exp_bit = 1'b1;
      if (fsk_bit !== exp_bit) bad_line++;
      if (k > BP && k <= 13 * BP && ((k - 1) % BP) == 0) got_cw[11 - (k - BP - 1) / BP] = fsk_bit;
      if (bit_strobe !== (k <= FRAME && ((k - 1) % BP) == 0)) bad_strobe++;
      if (bit_strobe === 1'b1) n_strobe++;
      if (busy !== (k <= FRAME) || fsk_en !== (k <= FRAME) || tx_ready !== (k == FRAME + 1)) bad_ctrl++;
      if (frame_done === 1'b1) done_cycle = (done_cycle == 0) ? k : -1;
      if (acc_cycle == 0 && tx_ready && tx_valid) acc_cycle = k;
    end
    chk({name, "_line"}, 32'(bad_line), 32'd0);
    chk({name, "_codeword"}, 32'(got_cw), 32'(exp_cw));
    chk({name, "_strobe_pattern"}, 32'(bad_strobe), 32'd0);
    chk({name, "_strobe_count"}, 32'(n_strobe), 32'd14);
    chk({name, "_ctrl"}, 32'(bad_ctrl), 32'd0);
    chk({name, "_done_cycle"}, 32'(done_cycle), 32'(FRAME));
    $display("frame %s: cw=%03h line_err=%0d strobes=%0d done@%0d", name, got_cw, bad_line, n_strobe, done_cycle);
  endtask

  initial begin
    int acc, bad, seen_done;
    logic [11:0] cw;
    logic [11:0] inj_cw;

`ifdef HAM_ERR_INJ_EN
    inj_cw = 12'h36A;
`else
    inj_cw = 12'h362;
`endif
    vecs[0] = '{data: 8'hA5, inj: 1'b0, pos: 4'd0,  exp_cw: 12'hA27};
    vecs[1] = '{data: 8'h3C, inj: 1'b1, pos: 4'd3,  exp_cw: inj_cw};
    vecs[2] = '{data: 8'h3C, inj: 1'b1, pos: 4'd13, exp_cw: 12'h362};
    vecs[3] = '{data: 8'h3C, inj: 1'b0, pos: 4'd3,  exp_cw: 12'h362};
    vecs[4] = '{data: 8'hFF, inj: 1'b0, pos: 4'd0,  exp_cw: 12'hF77};

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    err_inj  = 1'b0;
    err_pos  = 4'd0;

    // Reset state, then 50 idle cycles with no change
    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, tx_ready, fsk_bit, fsk_en, bit_strobe, busy, frame_done}, 32'b110000);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({tx_ready, fsk_bit, fsk_en, bit_strobe, busy, frame_done} !== 6'b110000) bad++;
    end
    chk("idle_stable", 32'(bad), 32'd0);
    $display("reset/idle: deviations=%0d", bad);

    // Table-driven single frames
    for (int v = 0; v < 5; v++) begin
      do_accept(vecs[v].data, vecs[v].inj, vecs[v].pos);
      watch_frame($sformatf("vec%0d", v), vecs[v].exp_cw, 1'b1, acc, cw);
      chk($sformatf("vec%0d_decode", v), 32'(ham_decode(cw)), 32'(vecs[v].data));
    end

    // Back-to-back: 00 then FF with tx_valid held throughout
    do_accept(8'h00, 1'b0, 4'd0);
    #1;
    tx_data  = 8'hFF;
    err_inj  = 1'b0;
    watch_frame("b2b_first", 12'h000, 1'b0, acc, cw);
    chk("b2b_spacing", 32'(acc), 32'(FRAME + 1));
    tx_data = 8'hFF;
    @(posedge clk);
    watch_frame("b2b_second", 12'hF77, 1'b1, acc, cw);

    // Reset during DATA bit 5, then a normal frame
    do_accept(8'hA5, 1'b0, 4'd0);
    #1;
    tx_valid = 1'b0;
    repeat (BP + 1 + 6 * BP) @(negedge clk);
    chk("pre_reset_in_bit5", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {26'd0, tx_ready, fsk_bit, fsk_en, bit_strobe, busy, frame_done}, 32'b110000);
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (frame_done) seen_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2 * BP; i++) begin
      @(negedge clk);
      if (frame_done) seen_done++;
    end
    chk("no_done_after_abort", 32'(seen_done), 32'd0);
    $display("mid-frame reset: frame_done pulses=%0d", seen_done);
    do_accept(8'hA5, 1'b0, 4'd0);
    watch_frame("after_reset", 12'hA27, 1'b1, acc, cw);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
